regfile_mp_bypass: RTL and testbench

- Parametrised multi-port general register file; successor to the single-write, two-read GRF.
- Adds N read ports and M write ports with fixed priority on write conflicts.
- Adds write-to-read bypass in the same cycle.
- Adds a per-register pending scoreboard so a long-latency unit (MDU) can reserve a destination register and the decode stage can see that the register is not yet valid.
- Sits between decode (reads, reserve) and writeback/MDU (writes).

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 64 ++++++
 rtl/regfile_mp_bypass.sv | 106 ++++++++++
 tb/tb_regfile_mp_bypass.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and constants for the multi-port register file and its
// pending-register scoreboard.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  // Register 0 is hardwired to zero: never written, never reserved.
  localparam int unsigned ZERO_REG = 0;

  // Write trace line, shared with the legacy two-read GRF trace checkers.
  localparam string TRACE_FMT = "@%h: $%d <= %h";

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy vector: reservation from decode, clear from the MDU
// write port, and the pending view seen by each read port.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic                     mdu_we,
  input  logic [ADDR_W-1:0]        mdu_wa,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic             rsv_fire;
  logic             clr_en;

  // Reserve handshake: a transfer happens in a cycle where rsv_valid and
  // rsv_ready are both high; the requester holds rsv_valid/rsv_addr stable
  // while rsv_ready is low. Address 0 is accepted and ignored.
  assign rsv_ready = (rsv_addr == ZERO_ADDR) || !busy[rsv_addr];
  assign rsv_fire  = rsv_valid && rsv_ready && (rsv_addr != ZERO_ADDR);
  assign clr_en    = mdu_we && (mdu_wa != ZERO_ADDR);

  // Set is applied after clear, so a same-address set and clear leaves it busy.
  always_comb begin
    busy_next = busy;
    if (clr_en) begin
      busy_next[mdu_wa] = 1'b0;
    end
    if (rsv_fire) begin
      busy_next[rsv_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // A same-cycle MDU write to the register resolves the hazard.
  always_comb begin
    rd_pending = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_pending[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]] &&
                      !(mdu_we && (mdu_wa == rd_addr[k*ADDR_W +: ADDR_W]));
    end
  end

endmodule

// File: rtl/regfile_mp_bypass.sv
// Multi-port general register file with highest-index write priority,
// same-cycle write-to-read bypass, write trace and a pending scoreboard.
module regfile_mp_bypass
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pending,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] wa,
  input  logic [NUM_WR*DATA_W-1:0] wd,
  input  logic [NUM_WR*32-1:0]     wpc,
  input  logic                     rsv_valid,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     rsv_ready
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int MDU   = NUM_WR - 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [NUM_WR-1:0] eff;
  logic [NUM_WR-1:0] win;

  // A port wins unless a higher-index effective port targets the same address.
  always_comb begin
    eff = '0;
    win = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      eff[j] = we[j] && (wa[j*ADDR_W +: ADDR_W] != ZERO_ADDR);
    end
    for (int j = 0; j < NUM_WR; j++) begin
      win[j] = eff[j];
      for (int k = j + 1; k < NUM_WR; k++) begin
        if (eff[k] && (wa[k*ADDR_W +: ADDR_W] == wa[j*ADDR_W +: ADDR_W])) begin
          win[j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (win[j]) begin
          mem[wa[j*ADDR_W +: ADDR_W]] <= wd[j*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (win[j]) begin
          $display("@%h: $%d <= %h", wpc[j*32 +: 32], wa[j*ADDR_W +: ADDR_W],
                   wd[j*DATA_W +: DATA_W]);
        end
      end
    end
  end

  // Ascending scan lets the highest-index matching write override the bypass.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_data[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
      for (int j = 0; j < NUM_WR; j++) begin
        if (eff[j] && (wa[j*ADDR_W +: ADDR_W] == rd_addr[k*ADDR_W +: ADDR_W])) begin
          rd_data[k*DATA_W +: DATA_W] = wd[j*DATA_W +: DATA_W];
        end
      end
      if (rd_addr[k*ADDR_W +: ADDR_W] == ZERO_ADDR) begin
        rd_data[k*DATA_W +: DATA_W] = '0;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_pending (rd_pending),
    .mdu_we     (we[MDU]),
    .mdu_wa     (wa[MDU*ADDR_W +: ADDR_W]),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .rsv_ready  (rsv_ready)
  );

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Directed bench for regfile_mp_bypass: bypass, write priority, register 0,
// reserve/clear handshake and reset behaviour.
module tb_regfile_mp_bypass;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_pending;
  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] wa;
  logic [NUM_WR*DATA_W-1:0] wd;
  logic [NUM_WR*32-1:0]     wpc;
  logic                     rsv_valid;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     rsv_ready;

  int n_checks;
  int n_pass;
  logic [DATA_W-1:0] exp_q[$];

  regfile_mp_bypass #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .we         (we),
    .wa         (wa),
    .wd         (wd),
    .wpc        (wpc),
    .rsv_valid  (rsv_valid),
    .rsv_addr   (rsv_addr),
    .rsv_ready  (rsv_ready)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard check
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_rd(input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic set_wr(input int port, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic [31:0] pc);
    we[port]                  = 1'b1;
    wa[port*ADDR_W +: ADDR_W] = a;
    wd[port*DATA_W +: DATA_W] = d;
    wpc[port*32 +: 32]        = pc;
  endtask

  function automatic logic [DATA_W-1:0] rd0();
    return rd_data[0 +: DATA_W];
  endfunction

  function automatic logic [DATA_W-1:0] rd1();
    return rd_data[DATA_W +: DATA_W];
  endfunction

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    reset     = 1'b1;
    rd_addr   = '0;
    we        = '0;
    wa        = '0;
    wd        = '0;
    wpc       = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    set_rd(5'd3, 5'd31);
    rsv_addr = 5'd3;
    sample();
    check("rst_rd0", rd0(), 0);
    check("rst_rd1", rd1(), 0);
    check("rst_pend", rd_pending, 0);
    check("rst_rsv_ready", rsv_ready, 1);
    rsv_addr = '0;

    // Single write with same-cycle bypass
    step();
    set_rd(5'd5, 5'd0);
    set_wr(0, 5'd5, 32'h1234_5678, 32'h0000_3000);
    exp_q.push_back(32'h1234_5678);
    sample();
    check("bypass_rd0", rd0(), 32'h1234_5678);
    step();
    we = '0;
    sample();
    check("stored_rd0", rd0(), exp_q.pop_front());

    // Write conflict: port 1 wins
    step();
    set_rd(5'd0, 5'd7);
    set_wr(0, 5'd7, 32'h0000_AAAA, 32'h0000_3004);
    set_wr(1, 5'd7, 32'h0000_BBBB, 32'h0000_3008);
    exp_q.push_back(32'h0000_BBBB);
    sample();
    check("conflict_bypass", rd1(), 32'h0000_BBBB);
    step();
    we = '0;
    sample();
    check("conflict_stored", rd1(), exp_q.pop_front());
    check("rd0_addr0", rd0(), 0);

    // Register 0 ignores writes
    step();
    set_rd(5'd0, 5'd0);
    set_wr(0, 5'd0, 32'h0000_FFFF, 32'h0000_300C);
    sample();
    check("r0_bypass", rd0(), 0);
    step();
    we = '0;
    sample();
    check("r0_stored", rd0(), 0);

    // Reserve 9, stall a second reservation, MDU write resolves it
    step();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    set_rd(5'd9, 5'd0);
    sample();
    check("rsv9_ready", rsv_ready, 1);
    check("rsv9_pend_before", rd_pending[0], 0);
    step();
    sample();
    check("rsv9_pend", rd_pending[0], 1);
    check("rsv9_second_stall", rsv_ready, 0);
    step();
    set_wr(1, 5'd9, 32'h0000_0042, 32'h0000_3010);
    sample();
    check("mdu_pend_cleared", rd_pending[0], 0);
    check("mdu_bypass", rd0(), 32'h0000_0042);
    check("mdu_rsv_still_stall", rsv_ready, 0);
    step();
    we = '0;
    sample();
    check("held_rsv_ready", rsv_ready, 1);
    check("held_pend_clear", rd_pending[0], 0);
    check("mdu_stored", rd0(), 32'h0000_0042);
    step();
    rsv_valid = 1'b0;
    sample();
    check("held_rsv_accepted", rd_pending[0], 1);

    // Free 9 again with an MDU write
    step();
    set_wr(1, 5'd9, 32'h0000_0055, 32'h0000_3014);
    step();
    we = '0;
    sample();
    check("free9", rd_pending[0], 0);

    // Same-cycle reserve and MDU clear: reservation wins
    step();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd9;
    set_wr(1, 5'd9, 32'h0000_0077, 32'h0000_3018);
    sample();
    check("setclr_ready", rsv_ready, 1);
    step();
    rsv_valid = 1'b0;
    we = '0;
    sample();
    check("setclr_busy", rd_pending[0], 1);
    check("setclr_data", rd0(), 32'h0000_0077);

    // Port 0 write does not clear busy
    step();
    set_wr(0, 5'd9, 32'h0000_0088, 32'h0000_301C);
    sample();
    check("p0_pend_same_cycle", rd_pending[0], 1);
    step();
    we = '0;
    sample();
    check("p0_no_clear", rd_pending[0], 1);
    check("p0_data", rd0(), 32'h0000_0088);

    // Reserve 4 and 6, then reset with a write in flight
    step();
    rsv_valid = 1'b1;
    rsv_addr  = 5'd4;
    step();
    rsv_addr  = 5'd6;
    step();
    rsv_valid = 1'b0;
    rsv_addr  = 5'd4;
    set_rd(5'd4, 5'd6);
    sample();
    check("pre_rst_pend", rd_pending, 2'b11);
    check("pre_rst_ready4", rsv_ready, 0);
    step();
    reset = 1'b1;
    set_wr(0, 5'd5, 32'h0000_DEAD, 32'h0000_3020);
    set_rd(5'd5, 5'd6);
    sample();
    check("during_rst_rd5", rd0(), 32'h0000_DEAD);
    check("during_rst_pend6", rd_pending[1], 1);
    step();
    reset = 1'b0;
    we = '0;
    sample();
    check("post_rst_rd5", rd0(), 0);
    check("post_rst_pend6", rd_pending[1], 0);
    check("post_rst_ready4", rsv_ready, 1);
    set_rd(5'd7, 5'd9);
    #1;
    check("post_rst_rd7", rd0(), 0);
    check("post_rst_pend9", rd_pending[1], 0);

    // MDU write to a register whose reservation was dropped by reset
    step();
    set_rd(5'd6, 5'd0);
    set_wr(1, 5'd6, 32'h0000_0099, 32'h0000_3024);
    step();
    we = '0;
    sample();
    check("late_mdu_data", rd0(), 32'h0000_0099);
    check("late_mdu_pend", rd_pending[0], 0);

    // Report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
